// File: rtl/debounce_pulse_tmr.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : debounce_pulse_tmr                                           |
// | Brief   : sync + debounce a raw level, pulse on debounced rising edge;  |
// |           define DEBOUNCE_TMR_EN to triplicate and vote state/counter. |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
module debounce_pulse_tmr #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic din_async,
  input  logic en,
  output logic pulse_out,
  output logic level_out,
  output logic tmr_err
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } stateT;

  localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_syncChain;
  logic                   w_sync;
  stateT                  w_state;
  stateT                  w_stateNxt;
  logic [CNT_W-1:0]       w_cnt;
  logic [CNT_W-1:0]       w_cntNxt;
  logic                   w_pulseNxt;
  logic                   w_levelNxt;
  logic                   r_pulse;
  logic                   r_level;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_syncChain <= '0;
    else       r_syncChain <= {r_syncChain[SYNC_STAGES-2:0], din_async};
  end

  assign w_sync = r_syncChain[SYNC_STAGES-1];

  // Next-state logic sees only the (voted) state and counter.
  always_comb begin
    w_stateNxt = w_state;
    w_cntNxt   = w_cnt;
    w_pulseNxt = 1'b0;
    w_levelNxt = r_level;
    case (w_state)
      IDLE_LO: begin
        if (en && w_sync) begin
          w_stateNxt = WAIT_HI;
          w_cntNxt   = '0;
        end
      end
      WAIT_HI: begin
        if (!en || !w_sync) begin
          w_stateNxt = IDLE_LO;
          w_cntNxt   = '0;
        end else if (w_cnt >= C_CNT_LAST) begin
          w_stateNxt = IDLE_HI;
          w_cntNxt   = '0;
          w_levelNxt = 1'b1;
          w_pulseNxt = 1'b1;
        end else begin
          w_cntNxt = w_cnt + 1'b1;
        end
      end
      IDLE_HI: begin
        if (en && !w_sync) begin
          w_stateNxt = WAIT_LO;
          w_cntNxt   = '0;
        end
      end
      WAIT_LO: begin
        if (!en || w_sync) begin
          w_stateNxt = IDLE_HI;
          w_cntNxt   = '0;
        end else if (w_cnt >= C_CNT_LAST) begin
          w_stateNxt = IDLE_LO;
          w_cntNxt   = '0;
          w_levelNxt = 1'b0;
        end else begin
          w_cntNxt = w_cnt + 1'b1;
        end
      end
      default: begin
        w_stateNxt = IDLE_LO;
        w_cntNxt   = '0;
      end
    endcase
  end

`ifdef DEBOUNCE_TMR_EN
  logic [1:0]       r_stateA;
  logic [1:0]       r_stateB;
  logic [1:0]       r_stateC;
  logic [CNT_W-1:0] r_cntA;
  logic [CNT_W-1:0] r_cntB;
  logic [CNT_W-1:0] r_cntC;
  logic             r_tmrErr;
  logic [1:0]       w_stateVote;
  logic             w_copyDiff;

  assign w_stateVote = (r_stateA & r_stateB) | (r_stateA & r_stateC) | (r_stateB & r_stateC);
  assign w_state     = stateT'(w_stateVote);
  assign w_cnt       = (r_cntA & r_cntB) | (r_cntA & r_cntC) | (r_cntB & r_cntC);
  assign w_copyDiff  = (r_stateA != w_stateVote) || (r_stateB != w_stateVote) ||
                       (r_stateC != w_stateVote) || (r_cntA != w_cnt) ||
                       (r_cntB != w_cnt) || (r_cntC != w_cnt);

  // Every copy reloads the voted next value, so one upset lasts one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stateA <= IDLE_LO;
      r_stateB <= IDLE_LO;
      r_stateC <= IDLE_LO;
      r_cntA   <= '0;
      r_cntB   <= '0;
      r_cntC   <= '0;
      r_pulse  <= 1'b0;
      r_level  <= 1'b0;
      r_tmrErr <= 1'b0;
    end else begin
      r_stateA <= w_stateNxt;
      r_stateB <= w_stateNxt;
      r_stateC <= w_stateNxt;
      r_cntA   <= w_cntNxt;
      r_cntB   <= w_cntNxt;
      r_cntC   <= w_cntNxt;
      r_pulse  <= w_pulseNxt;
      r_level  <= w_levelNxt;
      r_tmrErr <= w_copyDiff;
    end
  end

  assign tmr_err = r_tmrErr;
`else
  stateT            r_state;
  logic [CNT_W-1:0] r_cnt;

  assign w_state = r_state;
  assign w_cnt   = r_cnt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE_LO;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_stateNxt;
      r_cnt   <= w_cntNxt;
      r_pulse <= w_pulseNxt;
      r_level <= w_levelNxt;
    end
  end

  assign tmr_err = 1'b0;
`endif

  assign pulse_out = r_pulse;
  assign level_out = r_level;

endmodule
`default_nettype wire

// File: tb/tb_debounce_pulse_tmr.sv
`default_nettype none
// Testbench for debounce_pulse_tmr: directed latency scenarios plus a
// randomized run against a run-length reference model.
module tb_debounce_pulse_tmr;

  localparam int SS  = 2;
  localparam int DC  = 16;
  localparam int LAT = SS + DC;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic dinAsync = 1'b0;
  logic en = 1'b1;
  logic pulseOut;
  logic levelOut;
  logic tmrErr;

  int tests = 0;
  int fails = 0;

  debounce_pulse_tmr #(
    .SYNC_STAGES    (SS),
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (8)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .din_async(dinAsync),
    .en       (en),
    .pulse_out(pulseOut),
    .level_out(levelOut),
    .tmr_err  (tmrErr)
  );

  always #5 clk = ~clk;

  // Reference: the level flips once the synchronised input has disagreed
  // with it, with en high, for DC+1 consecutive clock samples.
  logic [SS-1:0] mSync;
  int            mRun;
  logic          mLevel;
  logic          mPulse;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mSync  <= '0;
      mRun   <= 0;
      mLevel <= 1'b0;
      mPulse <= 1'b0;
    end else begin
      mSync  <= {mSync[SS-2:0], dinAsync};
      mPulse <= 1'b0;
      if (en && (mSync[SS-1] != mLevel)) begin
        if (mRun == DC) begin
          mLevel <= mSync[SS-1];
          mPulse <= mSync[SS-1];
          mRun   <= 0;
        end else begin
          mRun <= mRun + 1;
        end
      end else begin
        mRun <= 0;
      end
    end
  end

  task automatic do_reset(input logic d);
    rstn     = 1'b0;
    dinAsync = d;
    en       = 1'b1;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  // Observe n edges starting with the next posedge (index 0).
  task automatic watch(input int n, output int firstPulse, output int nPulse,
                       output int levelEdge, output bit dbl);
    logic lvl0;
    logic prevP;
    firstPulse = -1;
    nPulse     = 0;
    levelEdge  = -1;
    dbl        = 1'b0;
    lvl0       = levelOut;
    prevP      = 1'b0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (pulseOut === 1'b1) begin
        if (firstPulse < 0) firstPulse = k;
        nPulse++;
        if (prevP) dbl = 1'b1;
      end
      prevP = (pulseOut === 1'b1);
      if (levelEdge < 0 && levelOut !== lvl0) levelEdge = k;
    end
  endtask

  task automatic test_reset();
    int fp, np, le;
    bit dbl;
    rstn     = 1'b0;
    dinAsync = 1'b1;
    en       = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if ({pulseOut, levelOut, tmrErr} !== 3'b000) begin
      fails++;
      $display("FAIL reset_outputs: pulse/level/err=%b%b%b required 000", pulseOut, levelOut, tmrErr);
    end
    rstn = 1'b1;
    watch(30, fp, np, le, dbl);
    tests++;
    if (fp !== LAT) begin
      fails++;
      $display("FAIL reset_latency: pulse at edge %0d required %0d", fp, LAT);
    end
    tests++;
    if (np !== 1) begin
      fails++;
      $display("FAIL reset_pulse_count: %0d pulses required 1", np);
    end
    tests++;
    if (le !== LAT || levelOut !== 1'b1) begin
      fails++;
      $display("FAIL reset_level: rose at edge %0d now %b required edge %0d now 1", le, levelOut, LAT);
    end
  endtask

  task automatic test_glitch();
    int fp, np, le;
    bit dbl;
    do_reset(1'b0);
    watch(3, fp, np, le, dbl);
    dinAsync = 1'b1;
    watch(10, fp, np, le, dbl);
    dinAsync = 1'b0;
    watch(5, fp, np, le, dbl);
    tests++;
    if (levelOut !== 1'b0 || np !== 0) begin
      fails++;
      $display("FAIL glitch_rejected: level=%b pulses=%0d required level 0 pulses 0", levelOut, np);
    end
    watch(20, fp, np, le, dbl);
    dinAsync = 1'b1;
    watch(30, fp, np, le, dbl);
    tests++;
    if (fp !== LAT || np !== 1) begin
      fails++;
      $display("FAIL glitch_recount: pulse edge %0d count %0d required edge %0d count 1", fp, np, LAT);
    end
  endtask

  task automatic test_fall();
    int fp, np, le;
    bit dbl;
    do_reset(1'b1);
    watch(25, fp, np, le, dbl);
    dinAsync = 1'b0;
    watch(30, fp, np, le, dbl);
    tests++;
    if (le !== LAT || levelOut !== 1'b0) begin
      fails++;
      $display("FAIL fall_level: fell at edge %0d now %b required edge %0d now 0", le, levelOut, LAT);
    end
    tests++;
    if (np !== 0) begin
      fails++;
      $display("FAIL fall_no_pulse: %0d pulses required 0", np);
    end
  endtask

  task automatic test_enable();
    int fp, np, le;
    bit dbl;
    do_reset(1'b0);
    watch(3, fp, np, le, dbl);
    dinAsync = 1'b1;
    watch(SS + 6, fp, np, le, dbl);
    en = 1'b0;
    watch(3, fp, np, le, dbl);
    tests++;
    if (np !== 0 || levelOut !== 1'b0) begin
      fails++;
      $display("FAIL enable_hold: pulses=%0d level=%b required 0 0", np, levelOut);
    end
    en = 1'b1;
    watch(30, fp, np, le, dbl);
    tests++;
    if (fp !== DC || np !== 1) begin
      fails++;
      $display("FAIL enable_restart: pulse %0d edges after re-entry count %0d required %0d count 1", fp, np, DC);
    end
  endtask

  task automatic test_reset_mid();
    int fp, np, le;
    bit dbl;
    do_reset(1'b1);
    watch(SS + 11, fp, np, le, dbl);
    rstn = 1'b0;
    #1;
    tests++;
    if ({pulseOut, levelOut, np} !== {2'b00, 32'd0}) begin
      fails++;
      $display("FAIL reset_mid_wait: pulse=%b level=%b pulses=%0d required 0 0 0", pulseOut, levelOut, np);
    end
    @(negedge clk);
    rstn = 1'b1;
    watch(25, fp, np, le, dbl);
    tests++;
    if (fp !== LAT || np !== 1) begin
      fails++;
      $display("FAIL reset_mid_relatch: pulse edge %0d count %0d required edge %0d count 1", fp, np, LAT);
    end
    rstn = 1'b0;
    #1;
    tests++;
    if (levelOut !== 1'b0) begin
      fails++;
      $display("FAIL reset_async_level: level=%b required 0", levelOut);
    end
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic test_tmr();
`ifdef DEBOUNCE_TMR_EN
    int fp, np, le;
    bit dbl;
    do_reset(1'b0);
    watch(4, fp, np, le, dbl);
    dut.r_stateB = 2'd2;
    @(posedge clk);
    @(negedge clk);
    tests++;
    if (tmrErr !== 1'b1 || dut.r_stateB !== 2'd0 || pulseOut !== 1'b0) begin
      fails++;
      $display("FAIL tmr_upset: err=%b copyB=%0d pulse=%b required 1 0 0", tmrErr, dut.r_stateB, pulseOut);
    end
    watch(3, fp, np, le, dbl);
    tests++;
    if (tmrErr !== 1'b0 || np !== 0 || levelOut !== 1'b0) begin
      fails++;
      $display("FAIL tmr_recover: err=%b pulses=%0d level=%b required 0 0 0", tmrErr, np, levelOut);
    end
`else
    do_reset(1'b1);
    repeat (25) @(negedge clk);
    tests++;
    if (tmrErr !== 1'b0) begin
      fails++;
      $display("FAIL tmr_tied: err=%b required 0", tmrErr);
    end
`endif
  endtask

  task automatic test_random();
    logic prevP;
    int   shown;
    shown = 0;
    prevP = 1'b0;
    do_reset(1'b0);
    for (int seg = 0; seg < 80; seg++) begin
      dinAsync = 1'($urandom_range(0, 1));
      en       = ($urandom_range(0, 9) != 0);
      for (int c = 0; c < int'($urandom_range(1, 30)); c++) begin
        @(posedge clk);
        @(negedge clk);
        tests++;
        if (pulseOut !== mPulse || levelOut !== mLevel || tmrErr !== 1'b0 ||
            (prevP && pulseOut === 1'b1)) begin
          fails++;
          if (shown < 10) begin
            shown++;
            $display("FAIL random_seg%0d: pulse/level/err=%b%b%b required %b%b0 (prev pulse %b)",
                     seg, pulseOut, levelOut, tmrErr, mPulse, mLevel, prevP);
          end
        end
        prevP = pulseOut;
      end
    end
    en = 1'b1;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_fall();
    test_enable();
    test_reset_mid();
    test_tmr();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
